// File: rtl/add_pipe.sv
// add_pipe: pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage.
// Latency: STAGES cycles from input transfer to out_valid; throughput one beat per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready combinationally.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake carrying x, y, c_in, sub
//   out_valid/out_ready  result handshake carrying sum, c_out, of, zero
// Optional feature: define ADD_PIPE_SAT_EN to saturate sum on signed overflow.
module add_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             of,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic adv;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic             vld_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] ye_q;
    logic [WIDTH-1:0] res_q;
    logic             cy_q;

    // Values arriving at this stage from the previous one (or the input port).
    logic             sv;
    logic [WIDTH-1:0] sx;
    logic [WIDTH-1:0] sye;
    logic [WIDTH-1:0] sres;
    logic             scy;

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] res_d;

    if (k == 0) begin : g_src
      assign sv   = in_valid;
      assign sx   = x;
      assign sye  = sub ? ~y : y;
      assign sres = '0;
      assign scy  = sub ? 1'b1 : c_in;
    end else begin : g_src
      assign sv   = g_stg[k-1].vld_q;
      assign sx   = g_stg[k-1].x_q;
      assign sye  = g_stg[k-1].ye_q;
      assign sres = g_stg[k-1].res_q;
      assign scy  = g_stg[k-1].cy_q;
    end

    assign chunk_sum = {1'b0, sx[k*CHUNK +: CHUNK]}
                     + {1'b0, sye[k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, scy};

    always_comb begin
      res_d                    = sres;
      res_d[k*CHUNK +: CHUNK]  = chunk_sum[CHUNK-1:0];
    end

    // Payload only loads with a valid beat, so bubbles leave the last
    // result in place instead of overwriting it with garbage.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        x_q   <= '0;
        ye_q  <= '0;
        res_q <= '0;
        cy_q  <= 1'b0;
      end else if (adv) begin
        vld_q <= sv;
        if (sv) begin
          x_q   <= sx;
          ye_q  <= sye;
          res_q <= res_d;
          cy_q  <= chunk_sum[CHUNK];
        end
      end
    end
  end

  // Carry into the MSB, recovered from the MSB sum bit of the final slice.
  logic cm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cm_q <= 1'b0;
    end else if (adv && g_stg[LAST].sv) begin
      cm_q <= g_stg[LAST].sx[WIDTH-1] ^ g_stg[LAST].sye[WIDTH-1]
            ^ g_stg[LAST].res_d[WIDTH-1];
    end
  end

  logic [WIDTH-1:0] res_w;

  assign res_w     = g_stg[LAST].res_q;
  assign out_valid = g_stg[LAST].vld_q;
  assign c_out     = g_stg[LAST].cy_q;
  assign of        = cm_q ^ g_stg[LAST].cy_q;

`ifdef ADD_PIPE_SAT_EN
  // Sign of x decides the overflow direction: x>=0 can only overflow upward.
  always_comb begin
    sum = res_w;
    if (of) begin
      sum = g_stg[LAST].x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum = res_w;
`endif

  // Gated by valid so the flag reads 0 out of reset rather than flagging the cleared sum.
  assign zero = out_valid && (sum == '0);

  // Only the MSB of x travels to the output; the rest of the final payload is dead.
  logic unused_payload;
  assign unused_payload = ^{g_stg[LAST].x_q, g_stg[LAST].ye_q};

endmodule

// File: tb/tb_add_pipe.sv
module tb_add_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic              c_in;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              c_out;
  logic              of;
  logic              zero;

  add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .of(of), .zero(zero)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     stall_cnt = 0;
  bit     rnd_done;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    longint      t;
    int          st;
  } exp_t;

  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb);
    exp_t   e;
    longint ua, ub, sa, sbv, u, s;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      u    = ua - ub;
      s    = sa - sbv;
      e.co = (ua >= ub);
    end else begin
      u    = ua + ub + longint'(ci);
      s    = sa + sbv + longint'(ci);
      e.co = (u >= (longint'(1) << 32));
    end
    e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.s  = u[31:0];
`ifdef ADD_PIPE_SAT_EN
    if (e.ov) e.s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    e.z  = (e.s == 32'h0);
    e.t  = 0;
    e.st = 0;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every output transfer, checks hold and latency.
  logic        held_v = 1'b0;
  logic [34:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (held_v) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_data", {29'd0, sum, c_out, of, zero}, {29'd0, held});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got sum=%0h with nothing expected", sum);
        end else begin
          e = q.pop_front();
          chk("sum",   {32'd0, sum},   {32'd0, e.s});
          chk("c_out", {63'd0, c_out}, {63'd0, e.co});
          chk("of",    {63'd0, of},    {63'd0, e.ov});
          chk("zero",  {63'd0, zero},  {63'd0, e.z});
          chk("latency", 64'(cyc - e.t), 64'(longint'(STAGES) + longint'(stall_cnt - e.st)));
        end
      end
      held_v = out_valid && !out_ready;
      held   = {sum, c_out, of, zero};
      if (held_v) stall_cnt++;
    end else begin
      held_v = 1'b0;
    end
  end

  // Driver: presents one beat, pushes its expected result when it transfers.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
    exp_t e;
    int   n = 0;
    x = a; y = b; c_in = ci; sub = sb; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e    = model(a, b, ci, sb);
        e.t  = cyc;
        e.st = stall_cnt;
        q.push_back(e);
        break;
      end
      n++;
      if (n > 100) begin
        chk("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_sum",       {32'd0, sum},       64'd0);
    chk("rst_flags",     {61'd0, c_out, of, zero}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed corner cases.
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1);
    send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
    wait_empty();

    // Back-to-back stream with a five-cycle output stall.
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'(i), 32'(i), 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_empty();

    // Randomized traffic with random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_empty();

    // Reset with three beats in flight: none of them may ever appear.
    send(32'h1111_1111, 32'h1, 1'b0, 1'b0);
    send(32'h2222_2222, 32'h2, 1'b0, 1'b0);
    send(32'h3333_3333, 32'h3, 1'b0, 1'b0);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
